// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Two-port arbiter/sequencer in front of a single-port data_memory. Requester 0 is the core
//   load/store path and requester 1 is the debug/loader path. One request is latched per
//   transaction, driven onto the memory port, and the result is returned with a done pulse.
//
// Parameters
//   W  data word width (matches data_memory)
//   N  address width (matches data_memory); all 2**N words are addressable, no wrap logic
//
// Ports
//   clk                 single clock, all state updates on posedge
//   rst                 synchronous active-low reset
//   req0/req1           request valid per requester (sampled only while idle)
//   we0/we1             1 = write, 0 = read
//   addr0/addr1         word address
//   wdata0/wdata1       write data
//   gnt0/gnt1           one-cycle pulse: request latched, requester may drop/change inputs
//   done0/done1         one-cycle pulse: transaction complete
//   rdata0/rdata1       read result, updated in the done cycle of a read and then held
//   address, write_data, MemWrite, MemRead   memory-side command
//   read_data           memory read data, valid one cycle after the MemRead cycle
//   busy                high whenever the sequencer is not idle
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined: on simultaneous requests the requester that did not win last
//                       time is granted. Undefined: fixed priority, requester 0 always wins.

module data_memory_arbiter #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] addr1,
  input  logic [W-1:0] wdata0,
  input  logic [W-1:0] wdata1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] rdata0,
  output logic [W-1:0] rdata1,
  output logic [N-1:0] address,
  output logic [W-1:0] write_data,
  output logic         MemWrite,
  output logic         MemRead,
  input  logic [W-1:0] read_data,
  output logic         busy
);

  // StAccess : command is being registered onto the memory port
  // StRead   : MemRead is visible to the memory this cycle
  // StResp   : read_data is valid, captured at the end of this cycle
  typedef enum logic [1:0] {StIdle, StAccess, StRead, StResp} state_e;

  state_e       state;
  logic         op_id;     // 0 = requester 0 owns the transaction, 1 = requester 1
  logic         op_we;
  logic [N-1:0] op_addr;
  logic [W-1:0] op_wdata;
  logic         winner;
  logic         any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic         last_grant;
`endif

  assign any_req = req0 | req1;
  assign busy    = (state != StIdle);

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      winner = ~last_grant;
    end else begin
      winner = ~req0;
    end
`else
    winner = ~req0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= StIdle;
      op_id      <= 1'b0;
      op_we      <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      address    <= '0;
      write_data <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      // Pulse outputs default low; only the states below raise them for one cycle.
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;

      unique case (state)
        StIdle: begin
          if (any_req) begin
            op_id    <= winner;
            op_we    <= winner ? we1 : we0;
            op_addr  <= winner ? addr1 : addr0;
            op_wdata <= winner ? wdata1 : wdata0;
            gnt0     <= ~winner;
            gnt1     <= winner;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= winner;
`endif
            state    <= StAccess;
          end
        end

        StAccess: begin
          address <= op_addr;
          if (op_we) begin
            // Write completes in the same cycle the memory sees MemWrite.
            MemWrite   <= 1'b1;
            write_data <= op_wdata;
            done0      <= ~op_id;
            done1      <= op_id;
            state      <= StIdle;
          end else begin
            MemRead <= 1'b1;
            state   <= StRead;
          end
        end

        StRead: begin
          state <= StResp;
        end

        StResp: begin
          if (op_id) begin
            rdata1 <= read_data;
          end else begin
            rdata0 <= read_data;
          end
          done0 <= ~op_id;
          done1 <= op_id;
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

  // Structural invariants of the memory command and handshake pulses.
  a_mem_excl: assert property (@(posedge clk) !(MemWrite && MemRead));
  a_gnt_excl: assert property (@(posedge clk) !(gnt0 && gnt1));
  a_done_excl: assert property (@(posedge clk) !(done0 && done1));

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

  localparam int W = 32;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [N-1:0] addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic         gnt0, gnt1, done0, done1;
  logic [W-1:0] rdata0, rdata1;
  logic [N-1:0] address;
  logic [W-1:0] write_data;
  logic         MemWrite, MemRead;
  logic [W-1:0] read_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .address    (address),
    .write_data (write_data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .read_data  (read_data),
    .busy       (busy)
  );

  // Stand-in for data_memory: synchronous write, registered read.
  logic [W-1:0] tb_mem [2**N];
  always @(posedge clk) begin
    if (MemWrite) tb_mem[address] <= write_data;
    if (MemRead) read_data <= tb_mem[address];
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected outputs are scheduled per cycle from the transaction timing rules:
  // gnt at T, memory command at T+1, write done at T+1, read done/data at T+3.
  typedef struct {
    bit           rstv, gnt0, gnt1, done0, done1, mw, mr, busy, acc, rdv0, rdv1;
    logic [N-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdval;
  } slot_t;

  slot_t        ring [8];
  slot_t        empty_slot;
  logic [W-1:0] mem_ref [2**N];
  int           cyc = 0;
  int           free_at = 0;
  bit           m_last = 1'b1;

  initial begin
    empty_slot = '{default: 0};
    foreach (ring[i]) ring[i] = empty_slot;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        foreach (ring[i]) ring[i] = empty_slot;
        ring[cyc % 8].rstv = 1'b1;
        free_at = cyc + 1;
        m_last  = 1'b1;
      end else if (cyc >= free_at && (req0 || req1)) begin
        bit           w;
        bit           wr;
        logic [N-1:0] a;
        logic [W-1:0] d;
`ifdef ARB_ROUND_ROBIN_EN
        if (req0 && req1) w = (m_last == 1'b0);
        else w = req1;
`else
        w = !req0;
`endif
        m_last = w;
        wr = w ? we1 : we0;
        a  = w ? addr1 : addr0;
        d  = w ? wdata1 : wdata0;
        if (w) ring[cyc % 8].gnt1 = 1'b1;
        else ring[cyc % 8].gnt0 = 1'b1;
        ring[cyc % 8].busy = 1'b1;
        ring[(cyc + 1) % 8].acc  = 1'b1;
        ring[(cyc + 1) % 8].addr = a;
        if (wr) begin
          ring[(cyc + 1) % 8].mw    = 1'b1;
          ring[(cyc + 1) % 8].wdata = d;
          if (w) ring[(cyc + 1) % 8].done1 = 1'b1;
          else ring[(cyc + 1) % 8].done0 = 1'b1;
          mem_ref[a] = d;
          free_at = cyc + 2;
        end else begin
          ring[(cyc + 1) % 8].mr   = 1'b1;
          ring[(cyc + 1) % 8].busy = 1'b1;
          ring[(cyc + 2) % 8].busy = 1'b1;
          ring[(cyc + 3) % 8].rdval = mem_ref[a];
          if (w) begin
            ring[(cyc + 3) % 8].done1 = 1'b1;
            ring[(cyc + 3) % 8].rdv1  = 1'b1;
          end else begin
            ring[(cyc + 3) % 8].done0 = 1'b1;
            ring[(cyc + 3) % 8].rdv0  = 1'b1;
          end
          free_at = cyc + 4;
        end
      end
    end
  end

  // Per-cycle compare against the scheduled expectations.
  logic [N-1:0] e_addr;
  logic [W-1:0] e_wdata, e_rd0, e_rd1;
  initial begin
    slot_t s;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        s = ring[cyc % 8];
        if (s.rstv) begin
          e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
        end
        if (s.acc) e_addr = s.addr;
        if (s.mw) e_wdata = s.wdata;
        if (s.rdv0) e_rd0 = s.rdval;
        if (s.rdv1) e_rd1 = s.rdval;
        chk("gnt0", {31'd0, gnt0}, {31'd0, s.gnt0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, s.gnt1});
        chk("done0", {31'd0, done0}, {31'd0, s.done0});
        chk("done1", {31'd0, done1}, {31'd0, s.done1});
        chk("MemWrite", {31'd0, MemWrite}, {31'd0, s.mw});
        chk("MemRead", {31'd0, MemRead}, {31'd0, s.mr});
        chk("busy", {31'd0, busy}, {31'd0, s.busy});
        chk("address", {27'd0, address}, {27'd0, e_addr});
        chk("write_data", write_data, e_wdata);
        chk("rdata0", rdata0, e_rd0);
        chk("rdata1", rdata1, e_rd1);
        ring[cyc % 8] = empty_slot;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input bit p, input bit we, input logic [N-1:0] a, input logic [W-1:0] d,
                     output int gcyc, output int dcyc);
    bit got;
    gcyc = -1;
    dcyc = -1;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (p ? gnt1 : gnt0) begin
        got = 1'b1;
        gcyc = cyc;
        if (p) req1 = 1'b0;
        else req0 = 1'b0;
      end
    end
    if (!got) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      if (p) req1 = 1'b0;
      else req0 = 1'b0;
    end else begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (p ? done1 : done0) begin
          got = 1'b1;
          dcyc = cyc;
        end
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_driver(input bit p, input int n);
    int g, dd;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      txn(p, 1'($urandom_range(0, 1)), N'($urandom_range(0, 31)), $urandom, g, dd);
    end
  endtask

  initial begin
    int g, d;
    int gq[$];
    int n1;
    bit got;
    for (int i = 0; i < 2**N; i++) begin
      tb_mem[i]  = $urandom;
      mem_ref[i] = tb_mem[i];
    end
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset held with both requests high.
    repeat (2) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    chk("rst_mem", {30'd0, MemWrite, MemRead}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rdata0 | rdata1, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Single write then read-back on requester 0.
    txn(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, g, d);
    chk("wr_latency", d - g, 32'd1);
    txn(1'b0, 1'b0, 5'd5, 32'h0, g, d);
    chk("rd_latency", d - g, 32'd3);
    chk("rd_deadbeef", rdata0, 32'hDEADBEEF);

    // Requester 1 fills and reads back the whole memory, 31 -> 0 included.
    for (int i = 0; i < 32; i++) txn(1'b1, 1'b1, N'(i), i * 32'h01010101, g, d);
    for (int i = 0; i < 32; i++) begin
      txn(1'b1, 1'b0, N'(i), 32'h0, g, d);
      chk("fill_rd", rdata1, i * 32'h01010101);
    end

    // Both requesters held high for four reads, arbitration order from reset.
    do_reset();
    we0 = 1'b0; we1 = 1'b0; addr0 = 5'd1; addr1 = 5'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 40 && gq.size() < 4; i++) begin
      @(negedge clk);
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("arb_count", gq.size(), 32'd4);
    while (gq.size() < 4) gq.push_back(9);
`ifdef ARB_ROUND_ROBIN_EN
    chk("arb_order", {gq[0][7:0], gq[1][7:0], gq[2][7:0], gq[3][7:0]}, 32'h00010001);
`else
    chk("arb_order", {gq[0][7:0], gq[1][7:0], gq[2][7:0], gq[3][7:0]}, 32'h00000000);
`endif
    repeat (6) @(negedge clk);

    // Reset in the capture cycle of a read aborts it.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd7;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1'b1;
    end
    req0 = 1'b0;
    chk("abort_gnt", {31'd0, got}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_rdata", rdata0, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    txn(1'b0, 1'b0, 5'd7, 32'h0, g, d);
    chk("post_abort_rd", d - g, 32'd3);

    // Short req1 pulse while busy is never granted.
    n1 = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1'b1;
    end
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd4; wdata1 = 32'h12345678;
    @(negedge clk);
    req1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt1 || done1) n1++;
    end
    chk("pulse_ignored", n1, 32'd0);

    // Random concurrent traffic from both requesters.
    fork
      rand_driver(1'b0, 60);
      rand_driver(1'b1, 60);
    join
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
